// File: rtl/cr_cceip_sa_pcore.sv
// Statistics accumulator core: per-counter event select, live/snapshot banks, 1-cycle register read.
// Optional: define CR_CCEIP_SA_SATURATE_EN to saturate counters at all-ones instead of wrapping.
module cr_cceip_sa_pcore #(
   parameter int unsigned N_CNT = 16,
   parameter int unsigned CNT_W = 50,
   parameter int unsigned N_EVT = 128,
   localparam int unsigned SEL_W = (N_EVT > 1) ? $clog2(N_EVT) : 1,
   localparam int unsigned IDX_W = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_EVT-1:0]       stat_events,
   input  logic [N_CNT*SEL_W-1:0] cfg_sel,
   input  logic [N_CNT-1:0]       cfg_en,
   input  logic                   regs_sa_snap,
   input  logic                   regs_sa_clear_live,
   input  logic                   rd_req,
   input  logic [IDX_W:0]         rd_idx,
   input  logic                   rd_snap,
   output logic                   rd_ack,
   output logic [CNT_W-1:0]       rd_data,
   output logic                   rd_err,
   output logic [N_CNT-1:0]       sa_ovf
);

   // Event bus padded to the full select range so selects >= N_EVT read a constant 0.
   localparam int unsigned EVT_P = 1 << SEL_W;

   logic [EVT_P-1:0] evt_pad_c;
   logic [N_CNT-1:0] hit_c;
   logic [CNT_W-1:0] live [N_CNT];
   logic [CNT_W-1:0] snap [N_CNT];
   logic             rd_oor_c;
   logic [CNT_W-1:0] rd_val_c;

   assign evt_pad_c = EVT_P'(stat_events);

   // Per-counter increment qualifier
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < int'(N_CNT); i++) begin
         hit_c[i] = cfg_en[i] & evt_pad_c[cfg_sel[i*SEL_W +: SEL_W]];
      end
   end

   // Live counters, overflow flags and snapshot bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_CNT); i++) begin
            live[i] <= '0;
            snap[i] <= '0;
         end
         sa_ovf <= '0;
      end else begin
         if (regs_sa_snap) begin
            for (int i = 0; i < int'(N_CNT); i++) begin
               snap[i] <= live[i];
            end
         end
         if (regs_sa_clear_live) begin
            for (int i = 0; i < int'(N_CNT); i++) begin
               live[i] <= '0;
            end
            sa_ovf <= '0;
         end else begin
            for (int i = 0; i < int'(N_CNT); i++) begin
               if (hit_c[i]) begin
`ifdef CR_CCEIP_SA_SATURATE_EN
                  if (!(&live[i])) begin
                     live[i] <= live[i] + CNT_W'(1);
                  end
`else
                  live[i] <= live[i] + CNT_W'(1);
`endif
                  if (&live[i]) begin
                     sa_ovf[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   // Read mux over the pre-edge bank contents
   always_comb begin
      rd_oor_c = (32'(rd_idx) >= N_CNT);
      rd_val_c = '0;
      if (!rd_oor_c) begin
         rd_val_c = rd_snap ? snap[rd_idx[IDX_W-1:0]] : live[rd_idx[IDX_W-1:0]];
      end
   end

   // Read response register; rd_data holds between acks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ack  <= 1'b0;
         rd_err  <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_ack <= rd_req;
         rd_err <= rd_req & rd_oor_c;
         if (rd_req) begin
            rd_data <= rd_val_c;
         end
      end
   end

endmodule

// File: doc/cr_cceip_sa_pcore.md
CR_CCEIP_SA_PCORE -- requirements
Module: cr_cceip_sa_pcore

Interface
REQ-001 Parameter N_CNT, default 16, number of statistics counters (1..64).
REQ-002 Parameter CNT_W, default 50, counter width in bits (8..64).
REQ-003 Parameter N_EVT, default 128, width of the flattened stat-event bus (2..512).
REQ-004 Derived localparam SEL_W = $clog2(N_EVT), IDX_W = $clog2(N_CNT) (minimum 1).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 stat_events  in  N_EVT  one-cycle event pulses from all engines, concatenated.
REQ-008 cfg_sel  in  N_CNT*SEL_W  per-counter event select; counter i uses slice [i*SEL_W +: SEL_W].
REQ-009 cfg_en  in  N_CNT  per-counter enable; 0 freezes the live count.
REQ-010 regs_sa_snap  in  1  pulse: copy all live counts into snapshot bank.
REQ-011 regs_sa_clear_live  in  1  pulse: zero all live counts and overflow flags.
REQ-012 rd_req  in  1  read request, one cycle.
REQ-013 rd_idx  in  IDX_W+1  counter index to read.
REQ-014 rd_snap  in  1  1 = read snapshot bank, 0 = read live bank.
REQ-015 rd_ack  out  1  read completion pulse.
REQ-016 rd_data  out  CNT_W  read value.
REQ-017 rd_err  out  1  with rd_ack: index out of range.
REQ-018 sa_ovf  out  N_CNT  sticky per-counter overflow flags.

Function
REQ-019 Live counter i SHALL increment by 1 in the cycle after stat_events[cfg_sel slice i] is 1 and cfg_en[i] is 1.
REQ-020 A cfg_sel value >= N_EVT SHALL select no event; the counter holds.
REQ-021 Increment at all-ones SHALL follow the REQ-036/037 overflow rule and set sa_ovf[i] on the same edge.
REQ-022 On regs_sa_snap, every snapshot[i] SHALL load the registered live value present before that edge, excluding that cycle's increment.
REQ-023 On regs_sa_clear_live, every live count and sa_ovf bit SHALL become 0; an event in the same cycle SHALL be discarded.
REQ-024 snap and clear_live in the same cycle: snapshot takes the pre-clear value; live becomes 0.
REQ-025 Read latency SHALL be exactly 1 cycle: rd_req at edge n produces rd_ack=1 for one cycle after edge n+1.
REQ-026 rd_data SHALL equal the selected bank's registered value sampled at the rd_req edge.
REQ-027 A snapshot read coincident with regs_sa_snap SHALL return the old snapshot.
REQ-028 rd_idx >= N_CNT SHALL produce rd_ack=1, rd_err=1, rd_data=0.
REQ-029 Back-to-back rd_req every cycle SHALL be accepted; one rd_ack per request, in order.
REQ-030 rd_err SHALL be 0 whenever rd_ack is 0; rd_data SHALL hold its last value when rd_ack is 0.
REQ-031 A change to cfg_sel SHALL take effect on the next event cycle; the count is not cleared.

Reset
REQ-032 While rst_n=0, all live counts, snapshots and sa_ovf SHALL be 0.
REQ-033 While rst_n=0, rd_ack, rd_err and rd_data SHALL be 0.
REQ-034 A read in flight when reset asserts SHALL be dropped; no rd_ack after release.
REQ-035 The first event SHALL count on the first clock edge with rst_n=1.

Configuration
REQ-036 With CR_CCEIP_SA_SATURATE_EN defined, a counter at all-ones SHALL hold at all-ones on increment and set sa_ovf[i].
REQ-037 Without CR_CCEIP_SA_SATURATE_EN, a counter at all-ones SHALL wrap to 0 on increment and set sa_ovf[i]; all other behaviour is identical.

Verification
REQ-038 CNT_W=8, counter 0 sel=5, 10 pulses on stat_events[5] -> read live idx 0 returns 10, rd_err=0, one cycle after rd_req.
REQ-039 Counter at 0xFE, 3 events -> SATURATE_EN: 0xFF, sa_ovf[0]=1; else: 0x01, sa_ovf[0]=1.
REQ-040 Live=7, event plus snap plus clear_live in the same cycle -> snapshot 7, live 0, sa_ovf 0.
REQ-041 N_CNT=16, rd_req with rd_idx=16 -> rd_ack=1, rd_err=1, rd_data=0; next rd_req with idx 3 returns counter 3.
REQ-042 Reset asserted one cycle after rd_req -> no rd_ack; all counts 0 after release; event at the first edge counts to 1.
